// File: rtl/uart_word_packer.sv
// UART receiver (8N1, or 8E1 when UART_PARITY_EN is defined) that packs
// BYTES_PER_WORD bytes per word and writes them to a FIFO with back-pressure accounting.
module uart_word_packer #(
  parameter int UART_BPS          = 9600,
  parameter int CLK_FREQ          = 50_000_000,
  parameter int BYTES_PER_WORD    = 2,
  parameter int OUT_WIDTH         = 16,
  parameter int MSB_FIRST         = 1,
  parameter int IDLE_TIMEOUT_BITS = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 fifo_full,
  output logic [OUT_WIDTH-1:0] fifo_wr_data,
  output logic                 fifo_wr_en,
  output logic                 frame_err,
  output logic                 partial_drop,
  output logic [15:0]          drop_cnt
);

  localparam int BIT_CNT = CLK_FREQ / UART_BPS;
  localparam int CNT_W   = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam int TIMEOUT = IDLE_TIMEOUT_BITS * BIT_CNT;
  localparam int IDLE_W  = $clog2(TIMEOUT + 1);
  localparam int IDX_W   = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic [IDX_W-1:0]     byte_idx_q, byte_idx_d, lane;
  logic [OUT_WIDTH-1:0] word_q, word_d, wr_data_q, wr_data_d;
  logic [IDLE_W-1:0]    idle_q, idle_d;
  logic                 wr_en_q, wr_en_d, ferr_q, ferr_d, pdrop_q, pdrop_d;
  logic [15:0]          drop_q, drop_d;
  logic                 fall, mid, stop_ok, byte_valid;
`ifdef UART_PARITY_EN
  logic                 parity_ok_q, parity_ok_d;
`endif

  assign fall = rx_prev_q & ~rx_s_q;
  assign mid  = (baud_q == CNT_W'(BIT_CNT / 2));
`ifdef UART_PARITY_EN
  assign stop_ok = rx_s_q & parity_ok_q;
`else
  assign stop_ok = rx_s_q;
`endif
  assign lane = (MSB_FIRST != 0) ? IDX_W'(BYTES_PER_WORD - 1) - byte_idx_q : byte_idx_q;

  always_comb begin
    state_d    = state_q;
    baud_d     = (state_q == S_IDLE || baud_q == CNT_W'(BIT_CNT - 1)) ? '0 : baud_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    ferr_d     = 1'b0;
    pdrop_d    = 1'b0;
    drop_d     = drop_q;
    idle_d     = idle_q;
    byte_valid = 1'b0;
`ifdef UART_PARITY_EN
    parity_ok_d = parity_ok_q;
`endif

    // Baud counter runs from the start edge and wraps every bit; every state samples at its mid-point.
    case (state_q)
      S_IDLE:  if (fall) state_d = S_START;
      S_START: if (mid) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA: if (mid) begin
        shift_d   = {rx_s_q, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_PARITY_EN
        if (bit_idx_q == 3'd7) state_d = S_PARITY;
`else
        if (bit_idx_q == 3'd7) state_d = S_STOP;
`endif
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (mid) begin
        parity_ok_d = ((^shift_q) == rx_s_q);
        state_d     = S_STOP;
      end
`endif
      S_STOP: if (mid) begin
        state_d = S_IDLE;
        if (stop_ok) byte_valid = 1'b1;
        else         ferr_d     = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (byte_valid) begin
      word_d[{lane, 3'b000} +: 8] = shift_q;
      if (byte_idx_q == IDX_W'(BYTES_PER_WORD - 1)) begin
        byte_idx_d = '0;
        if (!fifo_full) begin
          wr_data_d = word_d;
          wr_en_d   = 1'b1;
        end else if (drop_q != 16'hFFFF) begin
          drop_d = drop_q + 16'd1;
        end
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
      end
    end

    // A falling edge in the same cycle as the timeout takes priority over the drop.
    if (state_q != S_IDLE) begin
      idle_d = '0;
    end else if (!fall && idle_q != IDLE_W'(TIMEOUT)) begin
      idle_d = idle_q + 1'b1;
      if (idle_q == IDLE_W'(TIMEOUT - 1) && byte_idx_q != '0) begin
        byte_idx_d = '0;
        pdrop_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      ferr_q     <= 1'b0;
      pdrop_q    <= 1'b0;
      drop_q     <= '0;
      idle_q     <= '0;
`ifdef UART_PARITY_EN
      parity_ok_q <= 1'b1;
`endif
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      rx_prev_q  <= rx_s_q;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      ferr_q     <= ferr_d;
      pdrop_q    <= pdrop_d;
      drop_q     <= drop_d;
      idle_q     <= idle_d;
`ifdef UART_PARITY_EN
      parity_ok_q <= parity_ok_d;
`endif
    end
  end

  assign fifo_wr_data = wr_data_q;
  assign fifo_wr_en   = wr_en_q;
  assign frame_err    = ferr_q;
  assign partial_drop = pdrop_q;
  assign drop_cnt     = drop_q;

endmodule
